// File: rtl/and64_operand_loader_pkg.sv
// Shared definitions for the 64-bit AND operand path: default widths and loader phase encoding.
package and64_operand_loader_pkg;

  localparam int unsigned DataWDefault  = 64;
  localparam int unsigned ChunkWDefault = 16;

  // Encoding is visible on the debug/LED port, so values are fixed.
  typedef enum logic [1:0] {
    StLoadA = 2'b00,
    StLoadB = 2'b01,
    StHold  = 2'b10
  } phase_e;

  function automatic logic is_load_phase(input phase_e ph);
    return (ph == StLoadA) || (ph == StLoadB);
  endfunction

endpackage

// File: rtl/and64_operand_loader.sv
// Assembles full-width AND operands A and B from narrow valid/ready beats, LSB chunk first,
// and holds them with op_valid_o until the consumer acknowledges.
module and64_operand_loader
  import and64_operand_loader_pkg::*;
#(
  parameter int unsigned DataW  = DataWDefault,
  parameter int unsigned ChunkW = ChunkWDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              soft_clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ChunkW-1:0] in_data_i,
  output logic              op_valid_o,
  input  logic              op_ack_i,
  output logic [DataW-1:0]  a_out_o,
  output logic [DataW-1:0]  b_out_o,
  output logic [1:0]        phase_o
);

  localparam int unsigned NumChunks = DataW / ChunkW;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(NumChunks - 1);

  phase_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DataW-1:0]  a_q;
  logic [DataW-1:0]  b_q;
  logic              op_valid_q;
  logic              last_beat;

  assign last_beat = (cnt_q == LastBeat);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StLoadA;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_valid_q <= 1'b0;
    end else if (soft_clr_i) begin
      // Clear wins over any beat or ack presented in the same cycle.
      state_q    <= StLoadA;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StLoadA: begin
          if (in_valid_i) begin
            a_q[int'(cnt_q)*ChunkW +: ChunkW] <= in_data_i;
            if (last_beat) begin
              cnt_q   <= '0;
              state_q <= StLoadB;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StLoadB: begin
          if (in_valid_i) begin
            b_q[int'(cnt_q)*ChunkW +: ChunkW] <= in_data_i;
            if (last_beat) begin
              cnt_q      <= '0;
              state_q    <= StHold;
              op_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (op_ack_i) begin
            state_q    <= StLoadA;
            cnt_q      <= '0;
            op_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StLoadA;
          cnt_q      <= '0;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready_o = is_load_phase(state_q);
    op_valid_o = op_valid_q;
    a_out_o    = a_q;
    b_out_o    = b_q;
    phase_o    = state_q;
  end

endmodule
